// File: rtl/mult_arbiter_if.sv
// Multiplier-side bus: operands and request out, ack/result/status back.
// The master is the arbiter; the slave is the parity-checked multiplier core.
interface mult_arbiter_if;
    logic        m_req;
    logic [15:0] m_arg_a;
    logic [15:0] m_arg_b;
    logic        m_arg_a_parity;
    logic        m_arg_b_parity;
    logic        m_ack;
    logic [31:0] m_result;
    logic        m_result_parity;
    logic        m_arg_parity_error;
    logic        m_result_rdy;

    modport master (
        output m_req, m_arg_a, m_arg_b, m_arg_a_parity, m_arg_b_parity,
        input  m_ack, m_result, m_result_parity, m_arg_parity_error, m_result_rdy
    );

    modport slave (
        input  m_req, m_arg_a, m_arg_b, m_arg_a_parity, m_arg_b_parity,
        output m_ack, m_result, m_result_parity, m_arg_parity_error, m_result_rdy
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin share of one 16x16 signed multiplier among NUM_REQ clients, one op in flight.
// Latency: arbitration, REQ, RESP cycles minimum, plus multiplier ack/ready delay.
// Clients hold c_req until c_done; optional watchdog enabled by MULT_ARB_TIMEOUT_EN.
module mult_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          c_req,
    input  logic [16*NUM_REQ-1:0]       c_arg_a,
    input  logic [NUM_REQ-1:0]          c_arg_a_parity,
    input  logic [16*NUM_REQ-1:0]       c_arg_b,
    input  logic [NUM_REQ-1:0]          c_arg_b_parity,
    output logic [NUM_REQ-1:0]          c_done,
    output logic [31:0]                 c_result,
    output logic                        c_result_parity,
    output logic                        c_parity_error,
    output logic                        c_timeout,
    mult_arbiter_if.master              mult,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id
);
    localparam int GRANT_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("mult_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RDY, RESP} state_t;

    state_t              state, state_nxt;
    logic [GRANT_W-1:0]  rr_ptr;
    logic [GRANT_W-1:0]  winner;
    logic [GRANT_W-1:0]  cand;
    logic                found;
    logic                grant_en;
    logic                capture;
    logic                timeout_go;
    logic                tmo_hit;
    logic                m_req_q;
    logic [15:0]         arg_a_q, arg_b_q;
    logic                arg_a_par_q, arg_b_par_q;

    function automatic logic [GRANT_W-1:0] wrap_idx(input logic [GRANT_W-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % NUM_REQ;
        return GRANT_W'(s);
    endfunction

    // Search starts just past the last winner, so a client that keeps requesting gets no repeat priority.
    always_comb begin
        winner = rr_ptr;
        cand   = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = wrap_idx(rr_ptr, k);
            if (!found && c_req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_en   = 1'b0;
        capture    = 1'b0;
        timeout_go = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_en  = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mult.m_ack && mult.m_result_rdy) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else if (tmo_hit) begin
                    timeout_go = 1'b1;
                    state_nxt  = RESP;
                end else if (mult.m_ack) begin
                    state_nxt = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (mult.m_result_rdy) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else if (tmo_hit) begin
                    timeout_go = 1'b1;
                    state_nxt  = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            rr_ptr          <= GRANT_W'(NUM_REQ - 1);
            grant_id        <= '0;
            m_req_q         <= 1'b0;
            arg_a_q         <= '0;
            arg_b_q         <= '0;
            arg_a_par_q     <= 1'b0;
            arg_b_par_q     <= 1'b0;
            c_result        <= '0;
            c_result_parity <= 1'b0;
            c_parity_error  <= 1'b0;
        end else begin
            state   <= state_nxt;
            m_req_q <= (state_nxt == REQ);
            if (grant_en) begin
                grant_id    <= winner;
                rr_ptr      <= winner;
                arg_a_q     <= c_arg_a[16*winner +: 16];
                arg_b_q     <= c_arg_b[16*winner +: 16];
                arg_a_par_q <= c_arg_a_parity[winner];
                arg_b_par_q <= c_arg_b_parity[winner];
            end
            if (capture) begin
                c_result        <= mult.m_result;
                c_result_parity <= mult.m_result_parity;
                c_parity_error  <= mult.m_arg_parity_error;
            end else if (timeout_go) begin
                c_result        <= '0;
                c_result_parity <= 1'b0;
                c_parity_error  <= 1'b0;
            end
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;

    // Count is zero in the first REQ cycle, so the op is abandoned after TIMEOUT_CYCLES cycles.
    assign tmo_hit = ((state == REQ) || (state == WAIT_RDY)) &&
                     (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt   <= '0;
            c_timeout <= 1'b0;
        end else begin
            if (grant_en)
                tmo_cnt <= '0;
            else if ((state == REQ) || (state == WAIT_RDY))
                tmo_cnt <= tmo_cnt + 1'b1;
            if (capture)
                c_timeout <= 1'b0;
            else if (timeout_go)
                c_timeout <= 1'b1;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign c_timeout = 1'b0;
`endif

    always_comb begin
        c_done = '0;
        if (state == RESP)
            c_done[grant_id] = 1'b1;
    end

    assign busy                = (state != IDLE);
    assign mult.m_req          = m_req_q;
    assign mult.m_arg_a        = arg_a_q;
    assign mult.m_arg_b        = arg_b_q;
    assign mult.m_arg_a_parity = arg_a_par_q;
    assign mult.m_arg_b_parity = arg_b_par_q;
endmodule
